hyperbus_trans_arb: RTL and testbench
=====================================

HYPERBUS_TRANS_ARB -- requirements
Module: hyperbus_trans_arb

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of upstream transaction ports, 1..8.
REQ-002 SHALL have parameter NumChips, default 2: chip-select width.
REQ-003 SHALL have parameter OrderLogDepth, default 2: log2 of the order-FIFO depth.
REQ-004 SHALL have parameter MaxOutstanding, default 2: maximum unfinished transfers per port, at least 1.
REQ-005 SHALL have type parameters hyper_tx_t and hyper_rx_t, each carrying a field named last.
REQ-006 SHALL have one clock and a synchronous active-high reset: clk_i (input, 1) and rst_i (input, 1).
REQ-007 SHALL have upstream transfer ports: in_trans_i (input, NumPorts x hyper_tf_t), in_cs_i (input, NumPorts x NumChips), in_trans_valid_i (input, NumPorts), in_trans_ready_o (output, NumPorts).
REQ-008 SHALL have upstream data ports: in_tx_i, in_tx_valid_i, in_tx_ready_o; in_rx_o, in_rx_valid_o, in_rx_ready_i; in_b_error_o, in_b_valid_o, in_b_ready_i. All are per-port arrays.
REQ-009 SHALL have downstream ports, single instance each: out_trans_o, out_cs_o, out_trans_valid_o, out_trans_ready_i; out_tx_o, out_tx_valid_o, out_tx_ready_i; out_rx_i, out_rx_valid_i, out_rx_ready_o; out_b_error_i, out_b_valid_i, out_b_ready_o.
REQ-010 SHALL have busy_o (output, 1): high while the order FIFO is non-empty.

Function
REQ-011 SHALL treat a port as eligible when all three hold: in_trans_valid_i is set, its outstanding count is below MaxOutstanding, and the order FIFO is not full.
REQ-012 SHALL select among eligible ports round-robin, starting the search at the port after the last granted port; the pointer resets to port 0.
REQ-013 SHALL assert out_trans_valid_o whenever a port is selected, and SHALL hold the selection, out_trans_o and out_cs_o stable until out_trans_ready_i (lock register).
REQ-014 SHALL assert in_trans_ready_o[p] only for the selected port p, and only in the cycle out_trans_ready_i is high.
REQ-015 On a transfer handshake, SHALL push {port id, write flag, tx_done=0} into the order FIFO, increment outstanding[p], and advance the round-robin pointer.
REQ-016 SHALL route TX only when the FIFO head is a write with tx_done=0: in_tx_i[head] goes to out_tx_o and ready returns to that port only; all other in_tx_ready_o are 0.
REQ-017 SHALL set tx_done on the TX handshake carrying last=1.
REQ-018 SHALL route out_rx_i to in_rx_o[head] only when the head is a read, and SHALL pop the head on the RX handshake carrying last=1.
REQ-019 SHALL route b to in_b_*[head] only when the head is a write with tx_done=1, and SHALL pop the head on the b handshake.
REQ-020 SHALL hold out_rx_ready_o and out_b_ready_o at 0 when the FIFO is empty or the head type mismatches; no data is dropped.
REQ-021 On a pop, SHALL decrement outstanding[head].
REQ-022 SHALL apply push and pop in the same cycle correctly, including when the FIFO is full, and including increment and decrement of the same port's counter in one cycle (net zero).
REQ-023 SHALL let order-FIFO pointers wrap modulo 2^OrderLogDepth, with a separate full/empty count of OrderLogDepth+1 bits.

Reset
REQ-024 SHALL, while rst_i is high at a clk_i edge, clear the FIFO, the counters, the lock and the round-robin pointer.
REQ-025 SHALL drive all valid and ready outputs to 0 and busy_o to 0 after reset.
REQ-026 SHALL, if reset occurs mid-burst, discard in-flight state; upstream must also be reset, and no completion for pre-reset transfers is issued.

Configuration
REQ-027 With HYPERBUS_TRANS_ARB_STATS_EN defined, SHALL provide output grant_cnt_o (NumPorts x 16): per-port saturating grant counters, cleared by reset.
REQ-028 Without HYPERBUS_TRANS_ARB_STATS_EN, the port and the counters SHALL be absent.

Structure
REQ-029 The order-entry typedef (port id width $clog2(NumPorts) at least 1, write, tx_done) SHALL live in hyperbus_pkg next to hyper_tf_t.
REQ-030 The round-robin selector SHALL be sub-module hyperbus_rr_sel (request vector, pointer -> one-hot grant, any).

Verification
REQ-031 Ports 0 and 1 both hold requests continuously with ready=1 -> grants alternate 0,1,0,1; the pointer after reset starts the search at 0.
REQ-032 Port 0 issues 3 reads with MaxOutstanding=2 and no RX returned -> the 3rd is not granted until the first read's last RX beat is accepted.
REQ-033 Port 1 write then port 0 read, TX of 4 beats with last on the 4th -> TX is accepted only from port 1, then b goes to port 1, then RX goes to port 0.
REQ-034 out_trans_ready_i is held 0 for 5 cycles while port 1 raises a request -> out_trans_o, out_cs_o and the grant stay on port 0.
REQ-035 Order FIFO is full (4 entries) and the last RX completes in the same cycle a new request is pending -> pop and push both occur, and busy_o stays 1.
REQ-036 rst_i is asserted mid-write burst -> next cycle all valid and ready outputs are 0, busy_o is 0, and with STATS_EN grant_cnt_o is 0.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus transaction types, plus the order-FIFO entry used by the
// transaction arbiter to remember which port owns each outstanding transfer.
package hyperbus_pkg;

    localparam int unsigned MAX_PORTS = 8;

    function automatic int unsigned port_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entries are sized for the largest supported port count so the type can be shared.
    localparam int unsigned PORT_ID_W = port_id_width(MAX_PORTS);

    typedef struct packed {
        logic        write;
        logic [15:0] burst;
        logic [31:0] address;
    } hyper_tf_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic        last;
    } hyper_tx_default_t;

    typedef struct packed {
        logic [15:0] data;
        logic        error;
        logic        last;
    } hyper_rx_default_t;

    typedef struct packed {
        logic [PORT_ID_W-1:0] port;
        logic                 write;
        logic                 tx_done;
    } order_entry_t;

endpackage

// File: rtl/hyperbus_rr_sel.sv
// Round-robin selector: one-hot grant to the first requester at or after ptr,
// wrapping around to port 0.
module hyperbus_rr_sel #(
    parameter int unsigned NumPorts = 2,
    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] req,
    input  logic [PtrW-1:0]     ptr,
    output logic [NumPorts-1:0] gnt,
    output logic                any
);

    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int j = 0; j < NumPorts; j++) begin
            if (!any && req[j] && (j >= int'(ptr))) begin
                gnt[j] = 1'b1;
                any    = 1'b1;
            end
        end
        for (int j = 0; j < NumPorts; j++) begin
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hyperbus_trans_arb.sv
// Arbitrates upstream HyperBus transfers onto one downstream port and routes
// TX/RX/B in grant order. Define HYPERBUS_TRANS_ARB_STATS_EN for grant_cnt_o.
module hyperbus_trans_arb
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned NumChips       = 2,
    parameter int unsigned OrderLogDepth  = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter type hyper_tx_t = hyper_tx_default_t,
    parameter type hyper_rx_t = hyper_rx_default_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  hyper_tf_t           in_trans_i [NumPorts],
    input  logic [NumChips-1:0] in_cs_i [NumPorts],
    input  logic [NumPorts-1:0] in_trans_valid_i,
    output logic [NumPorts-1:0] in_trans_ready_o,
    input  hyper_tx_t           in_tx_i [NumPorts],
    input  logic [NumPorts-1:0] in_tx_valid_i,
    output logic [NumPorts-1:0] in_tx_ready_o,
    output hyper_rx_t           in_rx_o [NumPorts],
    output logic [NumPorts-1:0] in_rx_valid_o,
    input  logic [NumPorts-1:0] in_rx_ready_i,
    output logic [NumPorts-1:0] in_b_error_o,
    output logic [NumPorts-1:0] in_b_valid_o,
    input  logic [NumPorts-1:0] in_b_ready_i,
    output hyper_tf_t           out_trans_o,
    output logic [NumChips-1:0] out_cs_o,
    output logic                out_trans_valid_o,
    input  logic                out_trans_ready_i,
    output hyper_tx_t           out_tx_o,
    output logic                out_tx_valid_o,
    input  logic                out_tx_ready_i,
    input  hyper_rx_t           out_rx_i,
    input  logic                out_rx_valid_i,
    output logic                out_rx_ready_o,
    input  logic                out_b_error_i,
    input  logic                out_b_valid_i,
    output logic                out_b_ready_o,
    output logic                busy_o
`ifdef HYPERBUS_TRANS_ARB_STATS_EN
    ,
    output logic [15:0]         grant_cnt_o [NumPorts]
`endif
);

    localparam int unsigned Depth = 1 << OrderLogDepth;
    localparam int unsigned PtrW  = port_id_width(NumPorts);
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned FcW   = OrderLogDepth + 1;

    order_entry_t             fifo_q [Depth];
    logic [OrderLogDepth-1:0] wr_ptr_q, rd_ptr_q;
    logic [FcW-1:0]           count_q;
    logic [CntW-1:0]          outstanding_q [NumPorts];
    logic [PtrW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                     lock_q;
    logic [NumPorts-1:0]      lock_gnt_q;

    order_entry_t         head;
    logic                 empty, full;
    logic                 head_tx, head_rx, head_b;
    logic [NumPorts-1:0]  head_sel, pop_port, eligible, rr_gnt, gnt;
    logic                 rr_any, push, pop, tx_last_hs;
    logic [PORT_ID_W-1:0] gnt_id;

    assign head  = fifo_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = count_q[OrderLogDepth];
    assign busy_o = !empty;

    assign head_tx = !empty && head.write && !head.tx_done;
    assign head_rx = !empty && !head.write;
    assign head_b  = !empty && head.write && head.tx_done;

    assign pop = (head_rx && out_rx_valid_i && out_rx_ready_o && out_rx_i.last)
               || (head_b && out_b_valid_i && out_b_ready_o);

    // A pop in this cycle frees both a FIFO slot and the head port's credit,
    // so a full FIFO can still accept a push alongside the completing burst.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            head_sel[p] = !empty && (head.port == PORT_ID_W'(p));
            pop_port[p] = pop && head_sel[p];
            eligible[p] = in_trans_valid_i[p]
                        && ((outstanding_q[p] < CntW'(MaxOutstanding)) || pop_port[p])
                        && (!full || pop);
        end
    end

    hyperbus_rr_sel #(.NumPorts(NumPorts)) u_rr_sel (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    assign gnt               = lock_q ? lock_gnt_q : rr_gnt;
    assign out_trans_valid_o = lock_q || rr_any;
    assign push              = out_trans_valid_o && out_trans_ready_i;
    assign in_trans_ready_o  = push ? gnt : '0;

    always_comb begin
        out_trans_o = '0;
        out_cs_o    = '0;
        gnt_id      = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int p = 0; p < NumPorts; p++) begin
            if (gnt[p]) begin
                out_trans_o = in_trans_i[p];
                out_cs_o    = in_cs_i[p];
                gnt_id      = PORT_ID_W'(p);
                rr_ptr_d    = (p == NumPorts - 1) ? '0 : PtrW'(p + 1);
            end
        end
    end

    always_comb begin
        out_tx_o       = '0;
        out_tx_valid_o = 1'b0;
        out_rx_ready_o = 1'b0;
        out_b_ready_o  = 1'b0;
        in_tx_ready_o  = '0;
        in_rx_valid_o  = '0;
        in_b_valid_o   = '0;
        in_b_error_o   = {NumPorts{out_b_error_i}};
        for (int p = 0; p < NumPorts; p++) begin
            in_rx_o[p] = out_rx_i;
            if (head_sel[p]) begin
                out_tx_o         = in_tx_i[p];
                out_tx_valid_o   = head_tx && in_tx_valid_i[p];
                in_tx_ready_o[p] = head_tx && out_tx_ready_i;
                in_rx_valid_o[p] = head_rx && out_rx_valid_i;
                out_rx_ready_o   = head_rx && in_rx_ready_i[p];
                in_b_valid_o[p]  = head_b && out_b_valid_i;
                out_b_ready_o    = head_b && in_b_ready_i[p];
            end
        end
    end

    assign tx_last_hs = out_tx_valid_o && out_tx_ready_i && out_tx_o.last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) fifo_q[i] <= '0;
            for (int p = 0; p < NumPorts; p++) outstanding_q[p] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
        end else begin
            if (out_trans_valid_o && !out_trans_ready_i) begin
                lock_q     <= 1'b1;
                lock_gnt_q <= gnt;
            end else if (push) begin
                lock_q <= 1'b0;
            end
            if (tx_last_hs) fifo_q[rd_ptr_q].tx_done <= 1'b1;
            if (push) begin
                fifo_q[wr_ptr_q].port    <= gnt_id;
                fifo_q[wr_ptr_q].write   <= out_trans_o.write;
                fifo_q[wr_ptr_q].tx_done <= 1'b0;
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_ptr_q <= rr_ptr_d;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + FcW'(push) - FcW'(pop);
            for (int p = 0; p < NumPorts; p++) begin
                if (push && gnt[p] && !pop_port[p])
                    outstanding_q[p] <= outstanding_q[p] + 1'b1;
                else if (pop_port[p] && !(push && gnt[p]))
                    outstanding_q[p] <= outstanding_q[p] - 1'b1;
            end
        end
    end

`ifdef HYPERBUS_TRANS_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) grant_cnt_o[p] <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++)
                if (push && gnt[p] && (grant_cnt_o[p] != 16'hFFFF))
                    grant_cnt_o[p] <= grant_cnt_o[p] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hyperbus_trans_arb.sv
// Directed bench for hyperbus_trans_arb with default parameters (2 ports,
// 4-entry order FIFO, 2 outstanding per port).
module tb_hyperbus_trans_arb;
    import hyperbus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hyper_tf_t         in_trans [2];
    logic [1:0]        in_cs [2];
    logic [1:0]        in_trans_valid, in_trans_ready;
    hyper_tx_default_t in_tx [2];
    logic [1:0]        in_tx_valid, in_tx_ready;
    hyper_rx_default_t in_rx [2];
    logic [1:0]        in_rx_valid, in_rx_ready;
    logic [1:0]        in_b_error, in_b_valid, in_b_ready;
    hyper_tf_t         out_trans;
    logic [1:0]        out_cs;
    logic              out_trans_valid, out_trans_ready;
    hyper_tx_default_t out_tx;
    logic              out_tx_valid, out_tx_ready;
    hyper_rx_default_t out_rx;
    logic              out_rx_valid, out_rx_ready;
    logic              out_b_error, out_b_valid, out_b_ready, busy;
`ifdef HYPERBUS_TRANS_ARB_STATS_EN
    logic [15:0]       grant_cnt [2];
`endif

    int total = 0;
    int bad   = 0;

    hyperbus_trans_arb dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .in_trans_i        (in_trans),
        .in_cs_i           (in_cs),
        .in_trans_valid_i  (in_trans_valid),
        .in_trans_ready_o  (in_trans_ready),
        .in_tx_i           (in_tx),
        .in_tx_valid_i     (in_tx_valid),
        .in_tx_ready_o     (in_tx_ready),
        .in_rx_o           (in_rx),
        .in_rx_valid_o     (in_rx_valid),
        .in_rx_ready_i     (in_rx_ready),
        .in_b_error_o      (in_b_error),
        .in_b_valid_o      (in_b_valid),
        .in_b_ready_i      (in_b_ready),
        .out_trans_o       (out_trans),
        .out_cs_o          (out_cs),
        .out_trans_valid_o (out_trans_valid),
        .out_trans_ready_i (out_trans_ready),
        .out_tx_o          (out_tx),
        .out_tx_valid_o    (out_tx_valid),
        .out_tx_ready_i    (out_tx_ready),
        .out_rx_i          (out_rx),
        .out_rx_valid_i    (out_rx_valid),
        .out_rx_ready_o    (out_rx_ready),
        .out_b_error_i     (out_b_error),
        .out_b_valid_i     (out_b_valid),
        .out_b_ready_o     (out_b_ready),
        .busy_o            (busy)
`ifdef HYPERBUS_TRANS_ARB_STATS_EN
        ,
        .grant_cnt_o       (grant_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        in_trans[0]     = '{write: 1'b0, burst: 16'd1, address: 32'h100};
        in_trans[1]     = '{write: 1'b0, burst: 16'd1, address: 32'h200};
        in_cs[0]        = 2'b01;
        in_cs[1]        = 2'b10;
        in_trans_valid  = '0;
        in_tx[0]        = '{data: 16'hAAAA, strb: 2'b11, last: 1'b0};
        in_tx[1]        = '{data: 16'h0000, strb: 2'b11, last: 1'b0};
        in_tx_valid     = '0;
        in_rx_ready     = '0;
        in_b_ready      = '0;
        out_trans_ready = 1'b0;
        out_tx_ready    = 1'b0;
        out_rx          = '{data: 16'h5A5A, error: 1'b0, last: 1'b0};
        out_rx_valid    = 1'b0;
        out_b_error     = 1'b0;
        out_b_valid     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (out_trans_valid !== 1'b0) begin bad++; $display("FAIL rst_trans_valid got %b want 0", out_trans_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (in_trans_ready !== 2'b00) begin bad++; $display("FAIL rst_trans_ready got %b want 00", in_trans_ready); end
        total++; if ({out_tx_valid, out_rx_ready, out_b_ready} !== 3'b000) begin bad++; $display("FAIL rst_data_hs got %b want 000", {out_tx_valid, out_rx_ready, out_b_ready}); end
    endtask

    task automatic test_rr_alternate();
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        do_reset();
        in_trans_valid  = 2'b11;
        out_trans_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 32'h100 : 32'h200;
            #1;
            total++; if (in_trans_ready !== exp_g) begin bad++; $display("FAIL rr_grant[%0d] got %b want %b", i, in_trans_ready, exp_g); end
            total++; if (out_trans.address !== exp_a) begin bad++; $display("FAIL rr_addr[%0d] got %h want %h", i, out_trans.address, exp_a); end
            tick();
        end
        #1;
        total++; if (out_trans_valid !== 1'b0) begin bad++; $display("FAIL rr_full_valid got %b want 0", out_trans_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy got %b want 1", busy); end
        in_trans_valid = 2'b00;
        out_rx.last    = 1'b1;
        out_rx_valid   = 1'b1;
        in_rx_ready    = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total++; if (in_rx_valid !== exp_g) begin bad++; $display("FAIL rr_rx_route[%0d] got %b want %b", i, in_rx_valid, exp_g); end
            tick();
        end
        out_rx_valid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_drained_busy got %b want 0", busy); end
    endtask

    task automatic test_outstanding();
        do_reset();
        in_trans_valid  = 2'b01;
        out_trans_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (in_trans_ready !== 2'b01) begin bad++; $display("FAIL os_grant[%0d] got %b want 01", i, in_trans_ready); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (out_trans_valid !== 1'b0) begin bad++; $display("FAIL os_blocked[%0d] got %b want 0", i, out_trans_valid); end
            tick();
        end
        out_rx_valid = 1'b1;
        out_rx.last  = 1'b0;
        in_rx_ready  = 2'b01;
        #1;
        total++; if (out_trans_valid !== 1'b0) begin bad++; $display("FAIL os_mid_beat got %b want 0", out_trans_valid); end
        total++; if (in_rx_valid !== 2'b01) begin bad++; $display("FAIL os_rx_route got %b want 01", in_rx_valid); end
        tick();
        out_rx.last = 1'b1;
        #1;
        total++; if (in_trans_ready !== 2'b01) begin bad++; $display("FAIL os_third_grant got %b want 01", in_trans_ready); end
        tick();
        out_rx_valid   = 1'b0;
        in_trans_valid = 2'b00;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_busy got %b want 1", busy); end
    endtask

    task automatic test_write_order();
        do_reset();
        in_trans[1].write = 1'b1;
        out_trans_ready   = 1'b1;
        in_trans_valid    = 2'b10;
        #1;
        total++; if (in_trans_ready !== 2'b10) begin bad++; $display("FAIL wo_grant_wr got %b want 10", in_trans_ready); end
        tick();
        in_trans_valid = 2'b01;
        #1;
        total++; if (in_trans_ready !== 2'b01) begin bad++; $display("FAIL wo_grant_rd got %b want 01", in_trans_ready); end
        tick();
        in_trans_valid = 2'b00;
        in_tx_valid    = 2'b11;
        out_tx_ready   = 1'b1;
        out_rx.last    = 1'b1;
        out_rx_valid   = 1'b1;
        in_rx_ready    = 2'b11;
        out_b_valid    = 1'b1;
        in_b_ready     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            in_tx[1].data = 16'hB000 + 16'(i);
            in_tx[1].last = (i == 3);
            #1;
            total++; if (in_tx_ready !== 2'b10) begin bad++; $display("FAIL wo_tx_ready[%0d] got %b want 10", i, in_tx_ready); end
            total++; if (out_tx.data !== 16'hB000 + 16'(i)) begin bad++; $display("FAIL wo_tx_data[%0d] got %h want %h", i, out_tx.data, 16'hB000 + 16'(i)); end
            total++; if ({out_rx_ready, out_b_ready} !== 2'b00) begin bad++; $display("FAIL wo_hold_rx_b[%0d] got %b want 00", i, {out_rx_ready, out_b_ready}); end
            tick();
        end
        in_tx_valid = 2'b00;
        #1;
        total++; if (in_b_valid !== 2'b10) begin bad++; $display("FAIL wo_b_route got %b want 10", in_b_valid); end
        total++; if ({out_b_ready, out_rx_ready, in_tx_ready} !== 4'b1000) begin bad++; $display("FAIL wo_b_phase got %b want 1000", {out_b_ready, out_rx_ready, in_tx_ready}); end
        tick();
        #1;
        total++; if (in_rx_valid !== 2'b01) begin bad++; $display("FAIL wo_rx_route got %b want 01", in_rx_valid); end
        total++; if ({out_rx_ready, in_b_valid} !== 3'b100) begin bad++; $display("FAIL wo_rx_phase got %b want 100", {out_rx_ready, in_b_valid}); end
        tick();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wo_busy got %b want 0", busy); end
    endtask

    task automatic test_lock();
        do_reset();
        in_trans_valid  = 2'b01;
        out_trans_ready = 1'b1;
        #1;
        total++; if (in_trans_ready !== 2'b01) begin bad++; $display("FAIL lk_first got %b want 01", in_trans_ready); end
        tick();
        out_trans_ready     = 1'b0;
        in_trans[0].address = 32'h140;
        #1;
        total++; if (out_trans_valid !== 1'b1) begin bad++; $display("FAIL lk_valid got %b want 1", out_trans_valid); end
        tick();
        in_trans_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (out_trans.address !== 32'h140) begin bad++; $display("FAIL lk_addr[%0d] got %h want 140", i, out_trans.address); end
            total++; if (out_cs !== 2'b01) begin bad++; $display("FAIL lk_cs[%0d] got %b want 01", i, out_cs); end
            total++; if (in_trans_ready !== 2'b00) begin bad++; $display("FAIL lk_ready[%0d] got %b want 00", i, in_trans_ready); end
            tick();
        end
        out_trans_ready = 1'b1;
        #1;
        total++; if (in_trans_ready !== 2'b01) begin bad++; $display("FAIL lk_release got %b want 01", in_trans_ready); end
        tick();
        #1;
        total++; if (in_trans_ready !== 2'b10) begin bad++; $display("FAIL lk_next got %b want 10", in_trans_ready); end
        tick();
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp_g;
        do_reset();
        in_trans_valid  = 2'b11;
        out_trans_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_trans_valid = 2'b01;
        #1;
        total++; if (out_trans_valid !== 1'b0) begin bad++; $display("FAIL fp_full_blocks got %b want 0", out_trans_valid); end
        tick();
        out_rx.last  = 1'b1;
        out_rx_valid = 1'b1;
        in_rx_ready  = 2'b01;
        #1;
        total++; if (in_rx_valid !== 2'b01) begin bad++; $display("FAIL fp_pop_route got %b want 01", in_rx_valid); end
        total++; if (in_trans_ready !== 2'b01) begin bad++; $display("FAIL fp_push got %b want 01", in_trans_ready); end
        tick();
        in_trans_valid = 2'b00;
        out_rx_valid   = 1'b0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fp_busy got %b want 1", busy); end
        out_rx_valid = 1'b1;
        in_rx_ready  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            total++; if (in_rx_valid !== exp_g) begin bad++; $display("FAIL fp_drain[%0d] got %b want %b", i, in_rx_valid, exp_g); end
            tick();
        end
        out_rx_valid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fp_empty got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        in_trans[1].write = 1'b1;
        in_trans_valid    = 2'b10;
        out_trans_ready   = 1'b1;
        tick();
        in_trans_valid = 2'b00;
        in_tx_valid    = 2'b10;
        out_tx_ready   = 1'b1;
        #1;
        total++; if (in_tx_ready !== 2'b10) begin bad++; $display("FAIL rm_tx_before got %b want 10", in_tx_ready); end
        tick();
        rst          = 1'b1;
        out_b_valid  = 1'b1;
        in_b_ready   = 2'b11;
        out_rx.last  = 1'b1;
        out_rx_valid = 1'b1;
        in_rx_ready  = 2'b11;
        tick();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got %b want 0", busy); end
        total++; if ({out_trans_valid, out_tx_valid, out_rx_ready, out_b_ready} !== 4'b0000) begin bad++; $display("FAIL rm_down got %b want 0000", {out_trans_valid, out_tx_valid, out_rx_ready, out_b_ready}); end
        total++; if ({in_trans_ready, in_tx_ready, in_rx_valid, in_b_valid} !== 8'h00) begin bad++; $display("FAIL rm_up got %b want 0", {in_trans_ready, in_tx_ready, in_rx_valid, in_b_valid}); end
`ifdef HYPERBUS_TRANS_ARB_STATS_EN
        total++; if (grant_cnt[1] !== 16'd0) begin bad++; $display("FAIL rm_grant_cnt got %0d want 0", grant_cnt[1]); end
`endif
        rst = 1'b0;
        tick();
        #1;
        total++; if (in_b_valid !== 2'b00) begin bad++; $display("FAIL rm_no_stale_b got %b want 00", in_b_valid); end
        clr_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        test_reset();
        test_rr_alternate();
        test_outstanding();
        test_write_order();
        test_lock();
        test_full_push_pop();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
